req_arbiter8: RTL and testbench

- Registered 8-requester arbiter that shares one downstream resource among requesters `req[7:0]`.
- Built around the team's 8-to-3 highest-index-wins priority selection, extended with:
  - grant hold until release,
  - optional round-robin fairness,
  - a hold-time watchdog that forces re-arbitration.
- Sits between requesting agents and a shared datapath. It drives a one-hot grant plus an encoded owner index.

---
 rtl/req_arbiter8.sv | 116 +++++++++++
 tb/tb_req_arbiter8.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter8.sv
// Registered 8-requester arbiter: grant held until release, optional round-robin,
// and a hold-time watchdog that hands the grant on when others are waiting.
//
// state   | meaning
// --------+-----------------------------------------
// ST_IDLE | no owner, outputs zero
// ST_BUSY | owner is gnt_id, counter tracks hold time
module req_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rr_en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic             WDOG_EN   = (MAX_HOLD != 0);

  state_t           r_state;
  logic [7:0]       r_gnt;
  logic [2:0]       r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [2:0]       r_last_id;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_start;
  logic [3:0] w_win_all;
  logic [3:0] w_win_ex;
  logic       w_owner_req;
  logic       w_others;
  logic       w_wdog;
  logic       w_load;
  logic [2:0] w_load_id;
  logic       w_drop;

  // Search downward from last-1, wrapping; last is checked last. Fixed priority
  // is the same search anchored at 0, which makes index 7 the first candidate.
  function automatic logic [3:0] arb(input logic [7:0] cand, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = last - 3'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    w_start     = rr_en ? r_last_id : 3'd0;
    w_win_all   = arb(req, w_start);
    w_win_ex    = arb(req & ~r_gnt, w_start);
    w_owner_req = req[r_gnt_id];
    w_others    = |(req & ~r_gnt);
    w_wdog      = WDOG_EN && (r_state == ST_BUSY) && (r_cnt == HOLD_LAST) &&
                  w_owner_req && w_others;
    w_load      = 1'b0;
    w_load_id   = w_win_ex[2:0];
    w_drop      = 1'b0;
    if (r_state == ST_IDLE) begin
      w_load    = w_win_all[3];
      w_load_id = w_win_all[2:0];
    end else if (!w_owner_req) begin
      w_load = w_win_ex[3];
      w_drop = !w_win_ex[3];
    end else begin
      w_load = w_wdog;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last_id   <= '0;
      r_cnt       <= '0;
    end else begin
      r_timeout <= w_wdog;
      if (w_load) begin
        r_state     <= ST_BUSY;
        r_gnt       <= 8'd1 << w_load_id;
        r_gnt_id    <= w_load_id;
        r_gnt_valid <= 1'b1;
        r_last_id   <= w_load_id;
        r_cnt       <= '0;
      end else if (w_drop) begin
        r_state     <= ST_IDLE;
        r_gnt       <= '0;
        r_gnt_id    <= '0;
        r_gnt_valid <= 1'b0;
        r_cnt       <= '0;
      end else if (r_state == ST_BUSY && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed and soak bench for req_arbiter8 built with a 4-cycle watchdog.
module tb_req_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rr_en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  req_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rr_en(rr_en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic inv_checks(input logic [7:0] pg, input logic [7:0] pr, input logic [2:0] pid);
    check("onehot", 32'((gnt & (gnt - 8'd1)) == 8'd0), 32'd1);
    check("gnt_vs_id", 32'(gnt), 32'(gnt_valid ? (8'd1 << gnt_id) : 8'd0));
    check("gnt_valid", 32'(gnt_valid), 32'(|gnt));
    if (pg != 8'd0 && pr[pid] && !timeout) check("hold", 32'(gnt), 32'(pg));
  endtask

  initial begin
    logic [7:0] pg, pr, nr;
    logic [2:0] pid, cur;
    logic [2:0] rr_exp [8];
    int waitc [8];
    int holdc [8];
    int holdl [8];
    int max_wait;

    rst = 1'b1; rr_en = 1'b0; req = 8'hFF;

    // reset with all requests high, then first grant one edge later
    step(); step();
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_id", 32'(gnt_id), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    rst = 1'b0;
    step();
    check("first_gnt", 32'(gnt), 32'h80);
    check("first_id", 32'(gnt_id), 32'd7);

    // fixed priority with hold and bubble-free handover
    do_reset();
    rr_en = 1'b0; req = 8'h0A;
    step();
    check("fp_gnt", 32'(gnt), 32'h08);
    req = 8'h8A;
    step();
    check("fp_hold", 32'(gnt), 32'h08);
    req = 8'h82;
    step();
    check("fp_handover", 32'(gnt), 32'h80);
    check("fp_handover_id", 32'(gnt_id), 32'd7);
    check("fp_no_to", 32'(timeout), 32'd0);

    // round-robin rotation 7,6,...,0,7
    do_reset();
    rr_en = 1'b1; req = 8'hFF;
    step();
    check("rr_start", 32'(gnt_id), 32'd7);
    cur = 3'd7;
    rr_exp = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    for (int i = 0; i < 8; i++) begin
      req = 8'hFF & ~(8'd1 << cur);
      step();
      check("rr_seq", 32'(gnt_id), 32'(rr_exp[i]));
      cur = gnt_id;
    end

    // watchdog: 7 held against a waiting 0
    do_reset();
    rr_en = 1'b0; req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wd_hold", 32'(gnt), 32'h80);
      check("wd_hold_to", 32'(timeout), 32'd0);
    end
    step();
    check("wd_move", 32'(gnt), 32'h01);
    check("wd_pulse", 32'(timeout), 32'd1);
    step();
    check("wd_keep", 32'(gnt), 32'h01);
    check("wd_pulse_end", 32'(timeout), 32'd0);

    // lone owner never times out
    do_reset();
    req = 8'h80;
    for (int i = 0; i < 20; i++) begin
      step();
      check("lone_gnt", 32'(gnt), 32'h80);
      check("lone_to", 32'(timeout), 32'd0);
    end

    // release to idle, simultaneous release/request, reset mid-grant
    do_reset();
    req = 8'h04;
    step();
    check("rel_gnt", 32'(gnt), 32'h04);
    req = 8'h00;
    step();
    check("rel_valid", 32'(gnt_valid), 32'd0);
    check("rel_id", 32'(gnt_id), 32'd0);
    req = 8'h04;
    step();
    req = 8'h10;
    step();
    check("swap_gnt", 32'(gnt), 32'h10);
    req = 8'h04;
    step();
    check("regnt", 32'(gnt), 32'h04);
    rst = 1'b1;
    step();
    check("mid_rst", 32'(gnt), 32'h00);
    rst = 1'b0;
    step();
    check("post_rst", 32'(gnt), 32'h04);

    // soak 1: random requests and mode, invariants only
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      req = 8'($urandom);
      rr_en = 1'($urandom);
      pg = gnt; pr = req; pid = gnt_id;
      step();
      inv_checks(pg, pr, pid);
    end

    // soak 2: round-robin with sticky requesters, wait bound 7*4+7
    rr_en = 1'b1; req = 8'h00;
    step(); step();
    max_wait = 0;
    for (int i = 0; i < 8; i++) begin
      waitc[i] = 0; holdc[i] = 0; holdl[i] = 1;
    end
    for (int c = 0; c < 5000; c++) begin
      pg = gnt; pr = req; pid = gnt_id;
      step();
      inv_checks(pg, pr, pid);
      nr = req;
      for (int i = 0; i < 8; i++) begin
        if (pr[i] && !gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
        if (gnt[i]) begin
          holdc[i]++;
          if (holdc[i] >= holdl[i]) nr[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          nr[i] = 1'b1;
          holdc[i] = 0;
          holdl[i] = int'($urandom_range(5, 1));
        end
      end
      req = nr;
    end
    check("rr_max_wait_ok", 32'(max_wait <= 35), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
